nfc_host_sequencer: RTL and testbench
=====================================

# nfc_host_sequencer

Host-side command sequencer that sits directly upstream of the NAND flash controller (NFC). It takes one operation request at a time from the host: program page, read page, erase, reset or read ID. For each request it fills or drains the NFC page buffer over the BF_* port, issues the single-cycle nfc_strt/nfc_cmd/RWA start, waits for nfc_done, and returns one status response. It replaces the bench-side send/write_buffer/read_buffer sequencing with synthesizable RTL.

## Interface
- PAGE_BYTES, 2048: bytes per page transfer; BF_ad counts 0..PAGE_BYTES-1.
- ID_BYTES, 5: bytes drained from the buffer after read_id.
- TIMEOUT_CYCLES, 65535: watchdog limit in WAIT; only used with NFC_SEQ_TIMEOUT_EN.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in/out  1/1  request handshake; transfer when both are high.
- req_op  in  3  NFC opcode: 001 program, 010 read, 011 reset, 100 erase, 101 read_id.
- req_addr  in  16  row address forwarded to RWA.
- wr_valid / wr_ready / wr_data  in/out/in  1/1/8  program data stream, one byte per handshake.
- rd_valid / rd_ready / rd_data  out/in/out  1/1/8  read and read_id data stream.
- resp_valid / resp_ready  out/in  1/1  status handshake.
- resp_status  out  5  {illegal, timeout, PErr, EErr, RErr}.
- nfc_cmd  out  3  registered opcode to the NFC.
- nfc_strt  out  1  one-cycle start pulse.
- RWA  out  16  row address to the NFC.
- nfc_done  in  1  NFC operation finished, level.
- PErr, EErr, RErr  in  1 each  NFC error flags.
- BF_sel, BF_we  out  1 each  buffer select and write enable.
- BF_ad  out  11  buffer address.
- BF_din  out  8  buffer write data.
- BF_dou  in  8  buffer read data, valid one cycle after BF_ad.

## Operation
- States: IDLE, FILL, START, WAIT, DRAIN, RESP.
- IDLE:
  - req_ready=1. On handshake, latch op and addr into RWA and nfc_cmd. Clear the byte counter.
  - program goes to FILL. read, erase, reset and read_id go to START.
  - Any other opcode goes straight to RESP with illegal=1. No NFC activity occurs.
- FILL:
  - BF_sel=1 and wr_ready=1.
  - Each wr handshake drives BF_we=1, BF_din=wr_data and BF_ad=counter in the same cycle, then increments the counter.
  - After byte PAGE_BYTES-1, go to START.
- START: nfc_strt=1 for exactly one cycle, then WAIT. BF_sel=1 for program, read and read_id; 0 for erase and reset.
- WAIT:
  - Track the previous value of nfc_done. Exit on a 0->1 transition only; a level held high from the previous operation is ignored.
  - On that edge, latch PErr/EErr/RErr into status.
  - read goes to DRAIN with length PAGE_BYTES. read_id goes to DRAIN with length ID_BYTES. Other ops go to RESP.
- DRAIN:
  - Each byte takes 2 cycles minimum: present BF_ad=counter, then capture BF_dou into rd_data and assert rd_valid.
  - Hold rd_data and rd_valid until rd_ready. Then increment and issue the next address.
  - After the last byte is accepted, go to RESP.
- RESP: resp_valid=1 with status held stable until resp_ready, then IDLE. Status clears on the return to IDLE.
- BF_sel=0, BF_we=0 and BF_ad=0 whenever the state is IDLE or RESP.
- The counter is 12 bits wide and compares against the length minus 1. No wrap occurs inside a transfer.

## Timing
- Reset: all outputs 0 (req_ready, wr_ready, rd_valid, resp_valid, nfc_strt, nfc_cmd, RWA, BF_*). State goes to IDLE. req_ready rises on the first clk after rst deasserts.
- Reset mid-operation: aborts immediately. Outputs return to reset values. A partial FILL or DRAIN is discarded, and no response is issued.
- nfc_strt is asserted exactly one cycle after the last FILL byte, or after the request handshake for non-program ops.
- FILL sustains 1 byte/cycle with wr_valid held high. Program with no stalls: PAGE_BYTES+1 cycles from accept to nfc_strt.
- DRAIN sustains 1 byte per 2 cycles with rd_ready held high.
- Simultaneous PErr/EErr/RErr are all latched; status bits are independent.
- Error flags outside the nfc_done edge cycle are ignored.

## Configuration
- NFC_SEQ_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles in WAIT.
  - At TIMEOUT_CYCLES it forces RESP with timeout=1 and error bits 0. DRAIN is skipped.
- NFC_SEQ_TIMEOUT_EN undefined: no counter. WAIT is unbounded, and the timeout bit is tied 0.

## Test plan
- Program: addr 16'h0040, PAGE_BYTES bytes of pattern i[7:0] -> BF_ad 0..2047 with matching BF_din; one-cycle nfc_strt with nfc_cmd=001, RWA=0040; resp_status=0 after nfc_done.
- Read: addr 16'h0040, model returns BF_dou=~BF_ad[7:0], rd_ready toggled every other cycle -> 2048 bytes in order, no loss or duplicate, resp_status=0.
- Erase with EErr=1 at the nfc_done edge -> BF_sel stays 0, resp_status=5'b00010; read_id -> exactly 5 rd bytes.
- Illegal op 3'b111 -> no nfc_strt, resp_status=5'b10000; nfc_done held high from before the request -> sequencer stays in WAIT until a fresh rising edge.
- rst asserted at FILL byte 100 -> all outputs 0 asynchronously, req_ready=1 one cycle after release; next program starts at BF_ad=0.
- With NFC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, nfc_done never rises -> resp_status=5'b01000 at WAIT cycle 100.

Source files
------------

// File: rtl/nfc_host_sequencer_if.sv
// Host-side handshake bundle for nfc_host_sequencer: request, program-data,
// read-data and status streams. The master is the host, the slave is the sequencer.
interface nfc_host_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [15:0] req_addr;

   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_data;

   logic        rd_valid;
   logic        rd_ready;
   logic [7:0]  rd_data;

   logic        resp_valid;
   logic        resp_ready;
   logic [4:0]  resp_status;

   modport master (
      output req_valid, req_op, req_addr, wr_valid, wr_data, rd_ready, resp_ready,
      input  req_ready, wr_ready, rd_valid, rd_data, resp_valid, resp_status
   );

   modport slave (
      input  req_valid, req_op, req_addr, wr_valid, wr_data, rd_ready, resp_ready,
      output req_ready, wr_ready, rd_valid, rd_data, resp_valid, resp_status
   );
endinterface

// File: rtl/nfc_host_sequencer.sv
// Host command sequencer in front of the NAND flash controller: fills/drains the page
// buffer, pulses nfc_strt, waits for nfc_done. NFC_SEQ_TIMEOUT_EN adds a WAIT watchdog.
module nfc_host_sequencer #(
   parameter int PAGE_BYTES = 2048,
   parameter int ID_BYTES   = 5
`ifdef NFC_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   nfc_host_sequencer_if.slave host,
   output logic [2:0]          nfc_cmd_o,
   output logic                nfc_strt_o,
   output logic [15:0]         RWA_o,
   input  logic                nfc_done_i,
   input  logic                PErr_i,
   input  logic                EErr_i,
   input  logic                RErr_i,
   output logic                BF_sel_o,
   output logic                BF_we_o,
   output logic [10:0]         BF_ad_o,
   output logic [7:0]          BF_din_o,
   input  logic [7:0]          BF_dou_i
);

   localparam logic [2:0]  OP_PROG   = 3'b001;
   localparam logic [2:0]  OP_READ   = 3'b010;
   localparam logic [2:0]  OP_RESET  = 3'b011;
   localparam logic [2:0]  OP_ERASE  = 3'b100;
   localparam logic [2:0]  OP_RDID   = 3'b101;
   localparam logic [11:0] PAGE_LAST = 12'(PAGE_BYTES - 1);
   localparam logic [11:0] ID_LAST   = 12'(ID_BYTES - 1);
`ifdef NFC_SEQ_TIMEOUT_EN
   localparam logic [15:0] WD_LAST   = 16'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT, S_DRAIN, S_RESP} state_t;
   typedef enum logic [1:0] {D_FETCH, D_CAPT, D_HOLD} dphase_t;

   state_t      state_q;
   dphase_t     dphase_q;
   logic [11:0] cnt_q;
   logic [11:0] len_last_q;
   logic [2:0]  cmd_q;
   logic [15:0] rwa_q;
   logic        strt_q;
   logic        req_ready_q;
   logic        wr_ready_q;
   logic        rd_valid_q;
   logic [7:0]  rd_data_q;
   logic        resp_valid_q;
   logic [4:0]  status_q;
   logic        done_prev_q;
`ifdef NFC_SEQ_TIMEOUT_EN
   logic [15:0] wd_q;
`endif

   logic buf_op;
   logic done_rise;
   logic drain_last;
   logic wr_fire;

   assign buf_op     = (cmd_q == OP_PROG) || (cmd_q == OP_READ) || (cmd_q == OP_RDID);
   assign done_rise  = nfc_done_i && !done_prev_q;
   assign drain_last = (cnt_q == len_last_q);
   assign wr_fire    = (state_q == S_FILL) && host.wr_valid && wr_ready_q;

   assign host.req_ready   = req_ready_q;
   assign host.wr_ready    = wr_ready_q;
   assign host.rd_valid    = rd_valid_q;
   assign host.rd_data     = rd_data_q;
   assign host.resp_valid  = resp_valid_q;
   assign host.resp_status = status_q;
   assign nfc_cmd_o        = cmd_q;
   assign nfc_strt_o       = strt_q;
   assign RWA_o            = rwa_q;

   // While a byte waits for rd_ready the next address is already presented, so the
   // buffer output is ready the cycle after the handshake: 2 cycles per byte.
   always_comb begin
      BF_sel_o = 1'b0;
      BF_we_o  = 1'b0;
      BF_ad_o  = 11'd0;
      BF_din_o = 8'd0;
      case (state_q)
         S_FILL: begin
            BF_sel_o = 1'b1;
            BF_we_o  = wr_fire;
            BF_ad_o  = cnt_q[10:0];
            BF_din_o = wr_fire ? host.wr_data : 8'd0;
         end
         S_START, S_WAIT: BF_sel_o = buf_op;
         S_DRAIN: begin
            BF_sel_o = 1'b1;
            BF_ad_o  = (dphase_q == D_HOLD && !drain_last) ? cnt_q[10:0] + 11'd1 : cnt_q[10:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dphase_q     <= D_FETCH;
         cnt_q        <= 12'd0;
         len_last_q   <= 12'd0;
         cmd_q        <= 3'd0;
         rwa_q        <= 16'd0;
         strt_q       <= 1'b0;
         req_ready_q  <= 1'b0;
         wr_ready_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= 8'd0;
         resp_valid_q <= 1'b0;
         status_q     <= 5'd0;
         done_prev_q  <= 1'b0;
`ifdef NFC_SEQ_TIMEOUT_EN
         wd_q         <= 16'd0;
`endif
      end else begin
         done_prev_q <= nfc_done_i;
         strt_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (host.req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  cmd_q       <= host.req_op;
                  rwa_q       <= host.req_addr;
                  cnt_q       <= 12'd0;
                  case (host.req_op)
                     OP_PROG: begin
                        state_q    <= S_FILL;
                        wr_ready_q <= 1'b1;
                     end
                     OP_READ, OP_RESET, OP_ERASE, OP_RDID: begin
                        state_q <= S_START;
                        strt_q  <= 1'b1;
                     end
                     default: begin
                        state_q      <= S_RESP;
                        status_q     <= 5'b10000;
                        resp_valid_q <= 1'b1;
                     end
                  endcase
               end
            end
            S_FILL: begin
               if (wr_fire) begin
                  cnt_q <= cnt_q + 12'd1;
                  if (cnt_q == PAGE_LAST) begin
                     cnt_q      <= 12'd0;
                     wr_ready_q <= 1'b0;
                     strt_q     <= 1'b1;
                     state_q    <= S_START;
                  end
               end
            end
            S_START: begin
               state_q <= S_WAIT;
`ifdef NFC_SEQ_TIMEOUT_EN
               wd_q    <= 16'd0;
`endif
            end
            S_WAIT: begin
               if (done_rise) begin
                  status_q <= {2'b00, PErr_i, EErr_i, RErr_i};
                  cnt_q    <= 12'd0;
                  dphase_q <= D_FETCH;
                  if (cmd_q == OP_READ) begin
                     len_last_q <= PAGE_LAST;
                     state_q    <= S_DRAIN;
                  end else if (cmd_q == OP_RDID) begin
                     len_last_q <= ID_LAST;
                     state_q    <= S_DRAIN;
                  end else begin
                     resp_valid_q <= 1'b1;
                     state_q      <= S_RESP;
                  end
               end
`ifdef NFC_SEQ_TIMEOUT_EN
               else if (wd_q == WD_LAST) begin
                  status_q     <= 5'b01000;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  wd_q <= wd_q + 16'd1;
               end
`endif
            end
            S_DRAIN: begin
               case (dphase_q)
                  D_FETCH: dphase_q <= D_CAPT;
                  D_CAPT: begin
                     rd_data_q  <= BF_dou_i;
                     rd_valid_q <= 1'b1;
                     dphase_q   <= D_HOLD;
                  end
                  default: begin
                     if (host.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (drain_last) begin
                           resp_valid_q <= 1'b1;
                           state_q      <= S_RESP;
                        end else begin
                           cnt_q    <= cnt_q + 12'd1;
                           dphase_q <= D_CAPT;
                        end
                     end
                  end
               endcase
            end
            S_RESP: begin
               if (host.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  status_q     <= 5'd0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nfc_host_sequencer.sv
// Directed bench for nfc_host_sequencer: behavioural page buffer and NFC done/error
// driver; a vector table plus sequences for program, read, stale done, reset and timeout.
module tb_nfc_host_sequencer;
   localparam int PAGE = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   nfc_host_sequencer_if hs();

   logic [2:0]  nfc_cmd;
   logic        nfc_strt;
   logic [15:0] rwa;
   logic        nfc_done = 1'b0;
   logic        perr = 1'b0, eerr = 1'b0, rerr = 1'b0;
   logic        bf_sel, bf_we;
   logic [10:0] bf_ad;
   logic [7:0]  bf_din;
   logic [7:0]  bf_dou = 8'd0;

   int checks = 0;
   int errors = 0;

`ifdef NFC_SEQ_TIMEOUT_EN
   nfc_host_sequencer #(.TIMEOUT_CYCLES(100)) dut (
`else
   nfc_host_sequencer dut (
`endif
      .clk(clk), .rst_n(rst_n), .host(hs),
      .nfc_cmd_o(nfc_cmd), .nfc_strt_o(nfc_strt), .RWA_o(rwa),
      .nfc_done_i(nfc_done), .PErr_i(perr), .EErr_i(eerr), .RErr_i(rerr),
      .BF_sel_o(bf_sel), .BF_we_o(bf_we), .BF_ad_o(bf_ad), .BF_din_o(bf_din),
      .BF_dou_i(bf_dou)
   );

   // Page buffer model (read data = ~address, registered) and activity monitors.
   logic [7:0]  bf_mem [0:PAGE-1];
   int          cyc_total = 0, acc_cyc = 0, strt_cyc = 0;
   int          strt_total = 0, bfsel_total = 0, we_total = 0;
   logic [2:0]  strt_cmd = 3'd0;
   logic [15:0] strt_rwa = 16'd0;

   always @(posedge clk) begin
      cyc_total <= cyc_total + 1;
      bf_dou    <= ~bf_ad[7:0];
      if (hs.req_valid && hs.req_ready) acc_cyc <= cyc_total;
      if (nfc_strt) begin
         strt_total <= strt_total + 1;
         strt_cyc   <= cyc_total;
         strt_cmd   <= nfc_cmd;
         strt_rwa   <= rwa;
      end
      if (bf_sel) bfsel_total <= bfsel_total + 1;
      if (bf_we) begin
         bf_mem[bf_ad] <= bf_din;
         we_total      <= we_total + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_req(input logic [2:0] op, input logic [15:0] addr);
      int n = 0;
      hs.req_op = op;
      hs.req_addr = addr;
      hs.req_valid = 1'b1;
      while (!hs.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", 64'(n < 20), 64'd1);
      @(negedge clk);
      hs.req_valid = 1'b0;
   endtask

   task automatic fill(input int nbytes, input logic [7:0] xr, output int sent);
      int cyc = 0;
      sent = 0;
      while (sent < nbytes && cyc < 5000) begin
         if (hs.wr_ready) begin
            hs.wr_valid = 1'b1;
            hs.wr_data = 8'(sent) ^ xr;
            sent++;
         end else begin
            hs.wr_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      hs.wr_valid = 1'b0;
   endtask

   // mode 0: done rises 3 cycles after strt; 1: done stale-high, fresh edge at +11; 2: never.
   // Error inputs carry the inverted (noise) value in every cycle except the edge cycle.
   task automatic drive_done(input int mode, input int d, input logic [2:0] errs);
      logic [2:0] e;
      case (mode)
         0: begin nfc_done = (d == 3 || d == 4); e = (d == 3) ? errs : ~errs; end
         1: begin nfc_done = (d < 10 || d == 11); e = (d == 11) ? errs : ~errs; end
         default: begin nfc_done = 1'b0; e = ~errs; end
      endcase
      {perr, eerr, rerr} = e;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [15:0] addr, input logic [2:0] errs,
                         input int mode, input bit toggle, input logic [7:0] xr,
                         output logic [4:0] status, output int nbytes, output int rdelay,
                         output int span, output bit stable, output int strts,
                         output int bfsel, output int lat);
      int s0, b0, d, cyc, first, last, sent, rd_bad;
      bit fin, rdy;
      s0 = strt_total; b0 = bfsel_total;
      nbytes = 0; rdelay = -1; span = -1; stable = 1'b0; status = 5'd0;
      d = -1; fin = 1'b0; first = 0; last = 0; rd_bad = 0;
      if (mode == 1) begin
         nfc_done = 1'b1;
         repeat (2) @(negedge clk);
      end else begin
         nfc_done = 1'b0;
      end
      do_req(op, addr);
      if (op == 3'b001) begin
         fill(PAGE, xr, sent);
         chk("fill_count", 64'(sent), 64'(PAGE));
      end
      cyc = 0;
      while (!fin && cyc < 20000) begin
         if (d >= 0) d++;
         else if (nfc_strt) d = 0;
         drive_done(mode, d, errs);
         rdy = toggle ? cyc[0] : 1'b1;
         hs.rd_ready = rdy;
         if (hs.rd_valid && rdy) begin
            if (hs.rd_data !== ~(8'(nbytes))) rd_bad++;
            if (nbytes == 0) first = cyc;
            last = cyc;
            nbytes++;
         end
         if (hs.resp_valid) begin
            status = hs.resp_status;
            rdelay = d;
            hs.rd_ready = 1'b0;
            repeat (2) @(negedge clk);
            stable = hs.resp_valid && (hs.resp_status == status);
            hs.resp_ready = 1'b1;
            @(negedge clk);
            hs.resp_ready = 1'b0;
            chk("resp_release", 64'({hs.resp_valid, hs.req_ready, hs.resp_status}), 64'b0100000);
            fin = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("resp_seen", 64'(fin), 64'd1);
      nfc_done = 1'b0;
      {perr, eerr, rerr} = 3'b000;
      hs.rd_ready = 1'b0;
      if (nbytes > 1) span = last - first;
      chk("rd_data_order", 64'(rd_bad), 64'd0);
      strts = strt_total - s0;
      bfsel = bfsel_total - b0;
      lat = (strts > 0) ? strt_cyc - acc_cyc : -1;
      $display("op=%b addr=%h status=%b rd_bytes=%0d strts=%0d lat=%0d resp_delay=%0d",
               op, addr, status, nbytes, strts, lat, rdelay);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [15:0] addr;
      logic [2:0]  errs;
      int          mode;
      logic [4:0]  exp_status;
      int          exp_strts;
      int          exp_lat;
      int          exp_bytes;
      bit          exp_bfsel;
      int          exp_rdelay;
      int          exp_span;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [4:0] st;
      int nb, rdl, sp, ns, bs, lt, w0, bad, sent, s0;
      bit stb;

      //            op      addr      errs  md  status    strts lat bytes sel rdly span
      vecs[0] = '{3'b100, 16'h0123, 3'b010, 0, 5'b00010, 1,    1,  0,   1'b0, 4,  -1};
      vecs[1] = '{3'b011, 16'h0000, 3'b000, 0, 5'b00000, 1,    1,  0,   1'b0, 4,  -1};
      vecs[2] = '{3'b100, 16'hBEEF, 3'b111, 0, 5'b00111, 1,    1,  0,   1'b0, 4,  -1};
      vecs[3] = '{3'b101, 16'h0000, 3'b000, 0, 5'b00000, 1,    1,  5,   1'b1, 15,  8};
      vecs[4] = '{3'b111, 16'h1234, 3'b000, 0, 5'b10000, 0,   -1,  0,   1'b0, -1, -1};
      vecs[5] = '{3'b000, 16'h5555, 3'b000, 0, 5'b10000, 0,   -1,  0,   1'b0, -1, -1};
      vecs[6] = '{3'b011, 16'h0007, 3'b100, 1, 5'b00100, 1,    1,  0,   1'b0, 12, -1};
      vecs[7] = '{3'b101, 16'h0001, 3'b001, 0, 5'b00001, 1,    1,  5,   1'b1, 15,  8};

      hs.req_valid = 1'b0; hs.req_op = 3'd0; hs.req_addr = 16'd0;
      hs.wr_valid = 1'b0; hs.wr_data = 8'd0; hs.rd_ready = 1'b0; hs.resp_ready = 1'b0;

      // Reset state
      #2;
      chk("reset_outs_a", 64'({hs.req_ready, hs.wr_ready, hs.rd_valid, hs.resp_valid, nfc_strt,
                               nfc_cmd, rwa, hs.resp_status}), 64'd0);
      chk("reset_outs_b", 64'({bf_sel, bf_we, bf_ad, bf_din, hs.rd_data}), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("req_ready_before_clk", 64'(hs.req_ready), 64'd0);
      @(negedge clk);
      chk("req_ready_after_clk", 64'(hs.req_ready), 64'd1);

      // Full page program
      w0 = we_total;
      run_op(3'b001, 16'h0040, 3'b000, 0, 1'b0, 8'h00, st, nb, rdl, sp, stb, ns, bs, lt);
      chk("prog_status", 64'(st), 64'd0);
      chk("prog_strts", 64'(ns), 64'd1);
      chk("prog_latency", 64'(lt), 64'(PAGE + 1));
      chk("prog_cmd_rwa", 64'({strt_cmd, strt_rwa}), 64'({3'b001, 16'h0040}));
      chk("prog_we_count", 64'(we_total - w0), 64'(PAGE));
      chk("prog_bfsel", 64'(bs > 0), 64'd1);
      chk("prog_resp_delay", 64'(rdl), 64'd4);
      bad = 0;
      for (int i = 0; i < PAGE; i++) if (bf_mem[i] !== 8'(i)) bad++;
      chk("prog_buffer_content", 64'(bad), 64'd0);

      // Full page read, rd_ready toggling
      run_op(3'b010, 16'h0040, 3'b000, 0, 1'b1, 8'h00, st, nb, rdl, sp, stb, ns, bs, lt);
      chk("read_status", 64'(st), 64'd0);
      chk("read_bytes", 64'(nb), 64'(PAGE));
      chk("read_cmd_rwa", 64'({strt_cmd, strt_rwa}), 64'({3'b010, 16'h0040}));
      chk("read_latency", 64'(lt), 64'd1);

      // Vector table
      for (int v = 0; v < 8; v++) begin
         run_op(vecs[v].op, vecs[v].addr, vecs[v].errs, vecs[v].mode, 1'b0, 8'h00,
                st, nb, rdl, sp, stb, ns, bs, lt);
         chk($sformatf("v%0d_status", v), 64'(st), 64'(vecs[v].exp_status));
         chk($sformatf("v%0d_strts", v), 64'(ns), 64'(vecs[v].exp_strts));
         chk($sformatf("v%0d_latency", v), 64'(lt), 64'(vecs[v].exp_lat));
         chk($sformatf("v%0d_rd_bytes", v), 64'(nb), 64'(vecs[v].exp_bytes));
         chk($sformatf("v%0d_bfsel", v), 64'(bs > 0), 64'(vecs[v].exp_bfsel));
         chk($sformatf("v%0d_resp_delay", v), 64'(rdl), 64'(vecs[v].exp_rdelay));
         chk($sformatf("v%0d_rd_span", v), 64'(sp), 64'(vecs[v].exp_span));
         chk($sformatf("v%0d_resp_stable", v), 64'(stb), 64'd1);
         if (ns > 0)
            chk($sformatf("v%0d_cmd_rwa", v), 64'({strt_cmd, strt_rwa}),
                64'({vecs[v].op, vecs[v].addr}));
      end

      // Reset in the middle of FILL
      s0 = strt_total;
      do_req(3'b001, 16'h0077);
      fill(100, 8'h00, sent);
      hs.wr_valid = 1'b1;
      hs.wr_data = 8'd100;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_outs_a", 64'({hs.req_ready, hs.wr_ready, hs.rd_valid, hs.resp_valid, nfc_strt,
                                nfc_cmd, rwa, hs.resp_status}), 64'd0);
      chk("midrst_outs_b", 64'({bf_sel, bf_we, bf_ad, bf_din}), 64'd0);
      hs.wr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midrst_req_ready_early", 64'(hs.req_ready), 64'd0);
      @(negedge clk);
      chk("midrst_req_ready", 64'({hs.req_ready, hs.resp_valid, hs.wr_ready}), 64'b100);
      chk("midrst_no_strt", 64'(strt_total - s0), 64'd0);

      // Program after the abort must start at address 0
      w0 = we_total;
      run_op(3'b001, 16'h0041, 3'b000, 0, 1'b0, 8'h5A, st, nb, rdl, sp, stb, ns, bs, lt);
      chk("prog2_status", 64'(st), 64'd0);
      chk("prog2_we_count", 64'(we_total - w0), 64'(PAGE));
      bad = 0;
      for (int i = 0; i < PAGE; i++) if (bf_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
      chk("prog2_buffer_content", 64'(bad), 64'd0);

`ifdef NFC_SEQ_TIMEOUT_EN
      // Watchdog: nfc_done never rises
      run_op(3'b100, 16'h0011, 3'b000, 2, 1'b0, 8'h00, st, nb, rdl, sp, stb, ns, bs, lt);
      chk("timeout_status", 64'(st), 64'b01000);
      chk("timeout_delay", 64'(rdl), 64'd101);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end
endmodule
